atm_vault: RTL and testbench

Bank-side responder for the ATM controller's transaction strobes. It watches the six withdraw/deposit request lines, checks each request against the account balance and the cash held in the machine, and paces note dispensing for withdrawals. It keeps the account balance and the vault cash count and reports each outcome as a one-cycle accept or deny pulse. It sits downstream of the ATM controller FSM, on the same `clock`/`reset`.

---
 rtl/atm_pkg.sv | 19 +
 rtl/atm_req_decode.sv | 25 ++
 rtl/atm_vault.sv | 154 +++++++++++++++
 tb/tb_atm_vault.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared constants for the ATM vault responder: note amounts, FSM state
// encoding and transaction direction.
package atm_pkg;

  localparam logic [2:0] AMT_50K  = 3'd1;
  localparam logic [2:0] AMT_100K = 3'd2;
  localparam logic [2:0] AMT_200K = 3'd4;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_CHECK        = 3'd1;
  localparam logic [2:0] ST_DISPENSE     = 3'd2;
  localparam logic [2:0] ST_COMMIT       = 3'd3;
  localparam logic [2:0] ST_DENY         = 3'd4;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd5;

  localparam logic DIR_W = 1'b0;
  localparam logic DIR_D = 1'b1;

endpackage

// File: rtl/atm_req_decode.sv
// Combinational decode of the six request lines into direction, amount in
// units and a flag for more than one line asserted.
module atm_req_decode
  import atm_pkg::*;
(
  input  logic [2:0] w_lines,
  input  logic [2:0] d_lines,
  output logic       dir,
  output logic [2:0] amt,
  output logic       multi_hot
);

  logic [2:0] any_line;

  always_comb begin
    any_line  = w_lines | d_lines;
    dir       = (|w_lines) ? DIR_W : DIR_D;
    // Amount is only meaningful when a single line is high; multi-hot is denied.
    amt       = ({3{any_line[0]}} & AMT_50K)
              | ({3{any_line[1]}} & AMT_100K)
              | ({3{any_line[2]}} & AMT_200K);
    multi_hot = ($countones({d_lines, w_lines}) > 1);
  end

endmodule

// File: rtl/atm_vault.sv
// Bank-side responder: checks each withdraw/deposit request against balance
// and vault cash, paces note dispensing, and commits or denies the transaction.
module atm_vault
  import atm_pkg::*;
#(
  parameter int BAL_W        = 16,
  parameter int INIT_BALANCE = 20,
  parameter int INIT_VAULT   = 40,
  parameter int MAX_BALANCE  = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             W_50000,
  input  logic             W_100000,
  input  logic             W_200000,
  input  logic             D_50000,
  input  logic             D_100000,
  input  logic             D_200000,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] vault,
  output logic             busy,
  output logic             done,
  output logic             denied,
  output logic             dispense
);

  localparam logic [BAL_W:0] MAX_EXT = (BAL_W+1)'(MAX_BALANCE);

  logic [2:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             dir_q, dir_d;
  logic [2:0]       amt_q, amt_d;
  logic             multi_q, multi_d;
  logic             phase_q, phase_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] vault_q, vault_d;

  logic             req_any;
  logic             dec_dir;
  logic [2:0]       dec_amt;
  logic             dec_multi;
  logic [BAL_W:0]   amt_ext, bal_ext, vlt_ext;
  logic             deny;

  atm_req_decode u_decode (
    .w_lines   ({W_200000, W_100000, W_50000}),
    .d_lines   ({D_200000, D_100000, D_50000}),
    .dir       (dec_dir),
    .amt       (dec_amt),
    .multi_hot (dec_multi)
  );

  assign req_any = W_50000 | W_100000 | W_200000 | D_50000 | D_100000 | D_200000;

  always_comb begin
    amt_ext = (BAL_W+1)'(amt_q);
    bal_ext = {1'b0, balance_q};
    vlt_ext = {1'b0, vault_q};
    if (dir_q == DIR_W) begin
      deny = multi_q | (amt_ext > bal_ext) | (amt_ext > vlt_ext);
    end else begin
      deny = multi_q | ((bal_ext + amt_ext) > MAX_EXT) | ((vlt_ext + amt_ext) > MAX_EXT);
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_any;
    dir_d     = dir_q;
    amt_d     = amt_q;
    multi_d   = multi_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    balance_d = balance_q;
    vault_d   = vault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any && !req_q) begin
          state_d = ST_CHECK;
          dir_d   = dec_dir;
          amt_d   = dec_amt;
          multi_d = dec_multi;
        end
      end
      ST_CHECK: begin
        phase_d = 1'b0;
        cnt_d   = '0;
        if (deny)                 state_d = ST_DENY;
        else if (dir_q == DIR_W)  state_d = ST_DISPENSE;
        else                      state_d = ST_COMMIT;
      end
      ST_DISPENSE: begin
        // Phase 0 emits a pulse and counts it; phase 1 is the gap, after
        // which the last pulse's gap hands over to COMMIT.
        phase_d = ~phase_q;
        if (!phase_q) begin
          cnt_d = cnt_q + 3'd1;
        end else if (cnt_q == amt_q) begin
          state_d = ST_COMMIT;
          phase_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_COMMIT: begin
        state_d = ST_WAIT_RELEASE;
        if (dir_q == DIR_W) begin
          balance_d = balance_q - BAL_W'(amt_q);
          vault_d   = vault_q - BAL_W'(amt_q);
        end else begin
          balance_d = balance_q + BAL_W'(amt_q);
          vault_d   = vault_q + BAL_W'(amt_q);
        end
      end
      ST_DENY: state_d = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: begin
        if (!req_any) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      dir_q     <= DIR_W;
      amt_q     <= '0;
      multi_q   <= 1'b0;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      balance_q <= BAL_W'(INIT_BALANCE);
      vault_q   <= BAL_W'(INIT_VAULT);
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      dir_q     <= dir_d;
      amt_q     <= amt_d;
      multi_q   <= multi_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      balance_q <= balance_d;
      vault_q   <= vault_d;
    end
  end

  assign balance  = balance_q;
  assign vault    = vault_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_COMMIT);
  assign denied   = (state_q == ST_DENY);
  assign dispense = (state_q == ST_DISPENSE) && !phase_q;

endmodule

// File: tb/tb_atm_vault.sv
// Scoreboard bench for atm_vault: three instances with different parameter
// sets; stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_atm_vault;

  typedef struct {
    int kind;  // 0 dispense, 1 done, 2 denied
    int c;     // cycle at which the pulse is sampled
    int b;     // balance expected (after done / during denied)
    int v;     // vault expected
  } exp_t;

  logic        clock;
  logic        reset;
  logic [5:0]  lines_v [3];
  logic [15:0] bal_o [3];
  logic [15:0] vlt_o [3];
  logic        busy_o [3];
  logic        done_o [3];
  logic        den_o [3];
  logic        disp_o [3];

  exp_t exp_q [3][$];
  int   pend [3];
  int   pend_b [3];
  int   pend_v [3];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    atm_vault #(
      .BAL_W        (16),
      .INIT_BALANCE ((g == 1) ? 1 : 20),
      .INIT_VAULT   ((g == 2) ? 10 : 40),
      .MAX_BALANCE  ((g == 2) ? 22 : 1000)
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .W_50000  (lines_v[g][0]),
      .W_100000 (lines_v[g][1]),
      .W_200000 (lines_v[g][2]),
      .D_50000  (lines_v[g][3]),
      .D_100000 (lines_v[g][4]),
      .D_200000 (lines_v[g][5]),
      .balance  (bal_o[g]),
      .vault    (vlt_o[g]),
      .busy     (busy_o[g]),
      .done     (done_o[g]),
      .denied   (den_o[g]),
      .dispense (disp_o[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(int i, int kind, int c, int b, int v);
    exp_t e;
    e.kind = kind; e.c = c; e.b = b; e.v = v;
    exp_q[i].push_back(e);
  endtask

  task automatic push_wd(int i, int k, int n, int b, int v);
    for (int j = 0; j < n; j++) push(i, 0, k + 1 + 2 * j, 0, 0);
    push(i, 1, k + 1 + 2 * n, b, v);
  endtask

  task automatic start(int i, logic [5:0] l, output int k);
    @(negedge clock);
    #1;
    lines_v[i] = l;
    k = cyc + 1;
  endtask

  task automatic hold_release(int i, int n);
    repeat (n) @(negedge clock);
    #1;
    lines_v[i] = '0;
    repeat (3) @(negedge clock);
  endtask

  // Monitor
  initial begin
    int   kind;
    exp_t e;
    for (int i = 0; i < 3; i++) pend[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (pend[i] != 0) begin
          check($sformatf("balance_after_done[%0d]", i), int'(bal_o[i]), pend_b[i]);
          check($sformatf("vault_after_done[%0d]", i), int'(vlt_o[i]), pend_v[i]);
          pend[i] = 0;
        end
        if (disp_o[i] || done_o[i] || den_o[i]) begin
          kind = disp_o[i] ? 0 : (done_o[i] ? 1 : 2);
          check($sformatf("one_hot_pulse[%0d]", i),
                int'(disp_o[i]) + int'(done_o[i]) + int'(den_o[i]), 1);
          if (exp_q[i].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse[%0d]: got kind %0d expected none (cycle %0d)", i, kind, cyc);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("pulse_kind[%0d]", i), kind, e.kind);
            check($sformatf("pulse_cycle[%0d]", i), cyc, e.c);
            if (e.kind == 2) begin
              check($sformatf("balance_on_deny[%0d]", i), int'(bal_o[i]), e.b);
              check($sformatf("vault_on_deny[%0d]", i), int'(vlt_o[i]), e.v);
            end else if (e.kind == 1) begin
              pend[i] = 1; pend_b[i] = e.b; pend_v[i] = e.v;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int k;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) lines_v[i] = '0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy[%0d]", i), int'(busy_o[i]), 0);
      check($sformatf("rst_balance[%0d]", i), int'(bal_o[i]), (i == 1) ? 1 : 20);
      check($sformatf("rst_vault[%0d]", i), int'(vlt_o[i]), (i == 2) ? 10 : 40);
    end

    // Deposit 100k: 20->22, 40->42
    start(0, 6'b010000, k);
    push(0, 1, k + 1, 22, 42);
    hold_release(0, 10);

    // Withdraw 200k: 4 pulses, 22->18, 42->38
    start(0, 6'b000100, k);
    push_wd(0, k, 4, 18, 38);
    hold_release(0, 14);

    // Balance 1: 100k denied, 50k accepted to 0, then 50k denied at 0
    start(1, 6'b000010, k);
    push(1, 2, k + 1, 1, 40);
    hold_release(1, 4);
    start(1, 6'b000001, k);
    push_wd(1, k, 1, 0, 39);
    hold_release(1, 6);
    start(1, 6'b000001, k);
    push(1, 2, k + 1, 0, 39);
    hold_release(1, 4);

    // Multi-hot W50k+D50k denied; busy held while lines stay high
    start(0, 6'b001001, k);
    push(0, 2, k + 1, 18, 38);
    repeat (3) @(negedge clock);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      #1 check("busy_wait_release", int'(busy_o[0]), 1);
    end
    lines_v[0] = '0;
    repeat (2) @(negedge clock);
    check("busy_after_release", int'(busy_o[0]), 0);

    // MAX 22: deposit 200k denied, 100k reaches exactly 22
    start(2, 6'b100000, k);
    push(2, 2, k + 1, 20, 10);
    hold_release(2, 4);
    start(2, 6'b010000, k);
    push(2, 1, k + 1, 22, 12);
    hold_release(2, 6);

    // Reset after the 2nd dispense pulse; line held through reset restarts
    start(0, 6'b000100, k);
    push(0, 0, k + 1, 0, 0);
    push(0, 0, k + 3, 0, 0);
    while (cyc < k + 3) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy_o[0]), 0);
    check("midrst_done", int'(done_o[0]), 0);
    check("midrst_denied", int'(den_o[0]), 0);
    check("midrst_dispense", int'(disp_o[0]), 0);
    check("midrst_balance", int'(bal_o[0]), 20);
    check("midrst_vault", int'(vlt_o[0]), 40);
    check("midrst_balance_inst1", int'(bal_o[1]), 1);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    k = cyc + 1;
    push_wd(0, k, 4, 16, 36);
    hold_release(0, 14);

    for (int t = 0; t < 50; t++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0 &&
          pend[0] + pend[1] + pend[2] == 0) break;
      @(negedge clock);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("queue_drained[%0d]", i), exp_q[i].size(), 0);
      check($sformatf("pending_balance_check[%0d]", i), pend[i], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
